// File: rtl/ibusif_if.sv
// Instruction-bus and IF-stage signals of the fetch front end.
// The master modport is the fetch unit; the slave modport is the bus agent and consumer.
interface ibusif_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_rdy;
  logic [31:0] ibus_rdata;
  logic        ibus_err;
  logic [1:0]  ibusif_vld_size;
  logic        ibusif_pop;
  logic [1:0]  ibusif_pop_size;
  logic [31:0] ibusif_data;
  logic        ibusif_bus_err;
  logic        jmp;
  logic [31:0] jmp_addr;

  modport master (
    output ibus_req, ibus_addr, ibusif_vld_size, ibusif_data, ibusif_bus_err,
    input  ibus_rdy, ibus_rdata, ibus_err, ibusif_pop, ibusif_pop_size, jmp, jmp_addr
  );

  modport slave (
    input  ibus_req, ibus_addr, ibusif_vld_size, ibusif_data, ibusif_bus_err,
    output ibus_rdy, ibus_rdata, ibus_err, ibusif_pop, ibusif_pop_size, jmp, jmp_addr
  );
endinterface

// File: rtl/ibusif.sv
// Instruction fetch front end: word reads into a halfword prefetch queue whose head is shown
// to the IF stage as a 32-bit window; flushes and redirects on jump.
`ifndef RESET_PC
`define RESET_PC 32'h0000_0000
`endif

module ibusif #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = `RESET_PC
) (
  input  logic     clk,
  input  logic     rstn,
  ibusif_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   sum_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [15:0]      hw_q [DEPTH];
  logic [15:0]      hw_d [DEPTH];
  logic [DEPTH-1:0] err_q, err_d;
  ptr_t             rptr_q, rptr_d;
  cnt_t             count_q, count_d;
  logic [31:0]      fptr_q, fptr_d;
  logic [31:0]      addr_q, addr_d;
  logic             pending_q, pending_d;
  logic             discard_q, discard_d;
  logic             skip_lo_q, skip_lo_d;
  logic             halt_q, halt_d;

  function automatic ptr_t wrap(input sum_t v);
    return (v >= sum_t'(DEPTH)) ? ptr_t'(v - sum_t'(DEPTH)) : ptr_t'(v);
  endfunction

  ptr_t        rptr1, wptr0, wptr1;
  logic        has0, has1, err0, err1;
  logic [15:0] hw0, hw1;

  assign rptr1 = wrap(sum_t'(rptr_q) + sum_t'(1));
  assign wptr0 = wrap(sum_t'(rptr_q) + sum_t'(count_q));
  assign wptr1 = wrap(sum_t'(wptr0) + sum_t'(1));
  assign has0  = (count_q != '0);
  assign has1  = (count_q > cnt_t'(1));
  assign hw0   = has0 ? hw_q[rptr_q] : '0;
  assign hw1   = has1 ? hw_q[rptr1]  : '0;
  assign err0  = has0 & err_q[rptr_q];
  assign err1  = has1 & err_q[rptr1];

  assign bus.ibus_req       = pending_q;
  assign bus.ibus_addr      = addr_q;
  assign bus.ibusif_data    = {hw1, hw0};
  // A 32-bit instruction at the head also faults if its upper half came from a faulting word.
  assign bus.ibusif_bus_err = err0 | (err1 & (hw0[1:0] == 2'b11));

  always_comb begin
    if (!has0)              bus.ibusif_vld_size = 2'b00;
    else if (err0 || has1)  bus.ibusif_vld_size = 2'b11;
    else                    bus.ibusif_vld_size = 2'b01;
  end

  logic unused_bits;
  assign unused_bits = ^{bus.ibusif_pop_size[1], bus.jmp_addr[0]};

  logic rsp, do_push, start;
  cnt_t pop_want, pop_n, push_n;

  always_comb begin
    rsp      = pending_q & bus.ibus_rdy;
    do_push  = rsp & ~discard_q & ~bus.jmp;
    push_n   = do_push ? (skip_lo_q ? cnt_t'(1) : cnt_t'(2)) : '0;
    pop_want = bus.ibusif_pop_size[0] ? cnt_t'(1) : cnt_t'(2);
    pop_n    = '0;
    // Over-pops are clamped so the queue never underflows.
    if (bus.ibusif_pop) pop_n = (pop_want > count_q) ? count_q : pop_want;
    start    = ~pending_q & ~halt_q & ~bus.jmp & (count_q <= cnt_t'(DEPTH - 2));

    hw_d  = hw_q;
    err_d = err_q;
    if (do_push) begin
      if (skip_lo_q) begin
        hw_d[wptr0]  = bus.ibus_rdata[31:16];
        err_d[wptr0] = bus.ibus_err;
      end else begin
        hw_d[wptr0]  = bus.ibus_rdata[15:0];
        err_d[wptr0] = bus.ibus_err;
        hw_d[wptr1]  = bus.ibus_rdata[31:16];
        err_d[wptr1] = bus.ibus_err;
      end
    end

    rptr_d    = wrap(sum_t'(rptr_q) + sum_t'(pop_n));
    count_d   = count_q - pop_n + push_n;
    fptr_d    = do_push ? fptr_q + 32'd4 : fptr_q;
    skip_lo_d = do_push ? 1'b0 : skip_lo_q;
    halt_d    = halt_q | (do_push & bus.ibus_err);
    pending_d = start | (pending_q & ~bus.ibus_rdy);
    addr_d    = start ? fptr_q : addr_q;
    discard_d = rsp ? 1'b0 : discard_q;

    if (bus.jmp) begin
      count_d   = '0;
      halt_d    = 1'b0;
      fptr_d    = {bus.jmp_addr[31:2], 2'b00};
      skip_lo_d = bus.jmp_addr[1];
      discard_d = pending_q & ~bus.ibus_rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hw_q      <= '{default: '0};
      err_q     <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      fptr_q    <= RESET_ADDR;
      addr_q    <= RESET_ADDR;
      pending_q <= 1'b0;
      discard_q <= 1'b0;
      skip_lo_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      hw_q      <= hw_d;
      err_q     <= err_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      fptr_q    <= fptr_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      discard_q <= discard_d;
      skip_lo_q <= skip_lo_d;
      halt_q    <= halt_d;
    end
  end

  pop_overrun_a: assert property (@(posedge clk) disable iff (!rstn)
    (bus.ibusif_pop && !err0) |-> (pop_want <= count_q));

endmodule

// File: doc/ibusif.md
Name: ibusif

Overview:
- Instruction-fetch front end between the instruction bus and the IF stage.
- Issues word-aligned reads on the instruction bus and buffers the returned halfwords in a small prefetch queue.
- Presents the head of the queue to the IF stage as a 32-bit window with a valid-size indication and a fault flag.
- Flushes and redirects on pipeline jumps, including discarding an in-flight response.

Parameters:
- DEPTH, 4, queue capacity in halfwords; must be even and >= 4.
- RESET_ADDR, `RESET_PC, first fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- ibus_req  out  1  read request; held high with a stable ibus_addr until ibus_rdy.
- ibus_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- ibus_rdy  in  1  response valid, one cycle; completes the request. May assert in the first cycle of ibus_req.
- ibus_rdata  in  32  read data; qualified by ibus_rdy.
- ibus_err  in  1  bus fault for this response; qualified by ibus_rdy.
- ibusif_vld_size  out  2  queue occupancy: 00 empty, 01 one halfword, 11 two or more halfwords.
- ibusif_pop  in  1  consume from the head.
- ibusif_pop_size  in  2  only bit 0 is used: 1 pops one halfword, 0 pops two.
- ibusif_data  out  32  {halfword1, halfword0} at the head; each halfword not present reads as 0.
- ibusif_bus_err  out  1  fault on the instruction at the head.
- jmp  in  1  flush and redirect.
- jmp_addr  in  32  redirect target; halfword-aligned, bit 0 is ignored.

Behaviour:
- State held: queue of DEPTH {halfword, err} entries, occupancy count, fetch pointer fptr, pending flag, discard flag, skip_lo flag, halt flag.
- Reset values:
  - ibus_req = 0, fptr = RESET_ADDR, count = 0, all flags 0.
  - Outputs: ibusif_vld_size = 00, ibusif_data = 0, ibusif_bus_err = 0.
- Request start:
  - Condition: not pending, not halt, not jmp this cycle, and count <= DEPTH-2 using the registered count.
  - Action: ibus_req rises the next cycle with ibus_addr = fptr.
  - One outstanding request at most.
  - A request cannot be withdrawn; ibus_req and ibus_addr stay stable until ibus_rdy.
- Response (ibus_rdy while pending, discard = 0):
  - Push low then high halfword, each tagged with ibus_err. If skip_lo, push only the high halfword and clear skip_lo.
  - fptr += 4; pending clears.
  - The next request may start in the following cycle.
  - Pushed data is visible on the ibusif_* outputs one cycle after ibus_rdy.
- Response with discard = 1: data dropped, discard clears, no push.
- Fault: a pushed entry with err = 1 sets halt. No further requests are issued until jmp.
- Pop:
  - Removes 1 or 2 halfwords in the same cycle; new head is visible next cycle.
  - Push and pop in one cycle are legal: count += pushed - popped.
  - Popping more halfwords than present is illegal; the design must not corrupt state (assert in simulation).
- Fault reporting:
  - ibusif_bus_err = err0 | (err1 & (halfword0[1:0] == 2'b11)), where 0 is the head entry.
  - When err0 = 1, ibusif_vld_size reads 11 so the consumer can issue a fault pop.
- jmp (highest priority over pop and push in the same cycle):
  - count = 0, halt = 0.
  - fptr = {jmp_addr[31:2], 2'b00}; skip_lo = jmp_addr[1].
  - If pending and ibus_rdy is not asserted this cycle, discard = 1. If ibus_rdy is asserted this cycle, that response is dropped.
  - A new request may start the cycle after jmp, once any discarded response has completed.
- fptr wraps modulo 2^32.
- rstn low mid-transaction returns all state to reset values. The bus agent is assumed reset simultaneously.

Test Plan:
- Reset, then ibus_rdy = 1 on every request cycle, rdata 0x0000_0013 at 0x0, 0x0000_0013 at 0x4 -> first ibus_addr = RESET_ADDR; vld_size = 11 one cycle after the first rdy; no third request until pop.
- Word 0x4501_4505 (two compressed halfwords), pop_size = 1 twice -> data = 0x4501_4505 then 0x0000_4501; vld_size 11 -> 01 -> 00.
- jmp to 0x0000_0102 with no request pending -> next ibus_addr = 0x100; only the upper halfword is enqueued; vld_size = 01.
- jmp while the request to 0x8 is held for 3 cycles -> the 0x8 response is discarded; the next request goes to the jump target; the queue holds no data from 0x8.
- Response with ibus_err = 1 -> ibusif_bus_err = 1 and vld_size = 11 at the head; no further ibus_req until jmp.
- Low halfword 0x0003 (32-bit instr) then next word's low half with err -> bus_err = 1 when the straddling instruction reaches the head; pop_size = 1 with head 0x4505 and err1 set -> bus_err = 0.
